seg7_rx: RTL and testbench

Seven-segment display receiver: observes the time-multiplexed, active-low segment bus and one-hot digit-select lines driving a DE10-Standard HEX display and recovers the hex nibble shown on each digit. It is the decode-back path for the hex-to-segment encoding used on the board. It is used as an on-chip monitor and scoreboard source for display logic, and as a front end for capturing externally scanned displays. Each pattern must hold for a programmable number of cycles before it is accepted. Per-digit valid/error flags and a frame-complete pulse are produced.

---
 rtl/seg7_rx.sv | 128 ++++++++++++
 tb/tb_seg7_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_rx.sv
// Seven-segment receiver: watches a scanned active-low segment bus with one-hot digit selects
// and recovers per-digit hex nibbles once each pattern has been stable long enough.
module seg7_rx #(
  parameter int unsigned NDIG   = 6,
  parameter int unsigned STABLE = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [6:0]        segs_n_i,
  input  logic [NDIG-1:0]   dig_sel_i,
  output logic [4*NDIG-1:0] digits_o,
  output logic [NDIG-1:0]   dig_valid_o,
  output logic [NDIG-1:0]   dig_err_o,
  output logic              frame_done_o
);

  localparam int unsigned CntW = $clog2(STABLE + 2);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntAcc = CntW'(STABLE);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE + 1);
  localparam logic [NDIG-1:0] SelOne = NDIG'(1);

  logic [6:0]        s_seg_q;
  logic [NDIG-1:0]   s_sel_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic [NDIG-1:0]   seen_q, seen_d, seen_nxt;
  logic              frame_done_q, frame_done_d;
  logic              one_hot, accept, blank;
  logic [4:0]        glyph;

  // Returns {legal, nibble}; anything outside the 16 board glyphs is illegal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    cnt_d = CntOne;
    if ({segs_n_i, dig_sel_i} == {s_seg_q, s_sel_q}) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    end
  end

  assign one_hot = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - SelOne)) == '0);
  // cnt sits at STABLE for exactly one cycle per window, so this fires at most once.
  assign accept  = (cnt_q == CntAcc) && one_hot;
  assign glyph   = decode(s_seg_q);
  assign blank   = (s_seg_q == 7'h7F);

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_nxt     = seen_q | s_sel_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    if (accept) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (s_sel_q[i]) begin
          if (glyph[4]) begin
            digits_d[4*i +: 4] = glyph[3:0];
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d[i]   = !blank;
          end
        end
      end
      if (&seen_nxt) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_seg_q      <= 7'h7F;
      s_sel_q      <= '0;
      cnt_q        <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s_seg_q      <= segs_n_i;
      s_sel_q      <= dig_sel_i;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits_o     = digits_q;
  assign dig_valid_o  = valid_q;
  assign dig_err_o    = err_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_rx.sv
// Bench for seg7_rx: directed vectors push expected output snapshots (with their cycle) into a
// queue; a monitor pops one whenever the outputs change or frame_done pulses.
module tb_seg7_rx;
  localparam int NDIG   = 6;
  localparam int STABLE = 4;
  localparam int KNone  = 0;
  localparam int KLeg   = 1;
  localparam int KBlank = 2;
  localparam int KErr   = 3;

  typedef struct {
    int          cyc;
    logic [23:0] dig;
    logic [5:0]  val;
    logic [5:0]  err;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segs_n;
  logic [5:0]  dig_sel;
  logic [23:0] digits;
  logic [5:0]  dig_valid, dig_err;
  logic        frame_done;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  exp_t        q[$];
  logic [23:0] exp_dig = '0;
  logic [5:0]  exp_val = '0, exp_err = '0, exp_seen = '0;
  logic [35:0] prev;

  seg7_rx #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .segs_n_i    (segs_n),
    .dig_sel_i   (dig_sel),
    .digits_o    (digits),
    .dig_valid_o (dig_valid),
    .dig_err_o   (dig_err),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [35:0] snap;
    exp_t e;
    snap = {digits, dig_valid, dig_err};
    if (mon_en && (snap !== prev || frame_done !== 1'b0)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc=%0d got dig=%h val=%b err=%b fd=%b, none expected",
                 cyc, digits, dig_valid, dig_err, frame_done);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || digits !== e.dig || dig_valid !== e.val || dig_err !== e.err ||
            frame_done !== e.fd) begin
          errors++;
          $display("FAIL output_event: got cyc=%0d dig=%h val=%b err=%b fd=%b, want cyc=%0d dig=%h val=%b err=%b fd=%b",
                   cyc, digits, dig_valid, dig_err, frame_done, e.cyc, e.dig, e.val, e.err, e.fd);
        end
      end
    end
    prev = snap;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Presents one pattern for 'hold' edges; kind/nib are the hand-derived decode result.
  task automatic apply(input logic [6:0] seg, input logic [5:0] sel, input int hold,
                       input int kind, input logic [3:0] nib);
    int          c;
    exp_t        e;
    logic [23:0] nd;
    logic [5:0]  nv, ne;
    logic        fd;
    c = cyc;
    segs_n = seg;
    dig_sel = sel;
    if (kind != KNone) begin
      nd = exp_dig; nv = exp_val; ne = exp_err;
      for (int i = 0; i < NDIG; i++) begin
        if (sel[i]) begin
          if (kind == KLeg) begin
            nd[4*i +: 4] = nib; nv[i] = 1'b1; ne[i] = 1'b0;
          end else begin
            nv[i] = 1'b0; ne[i] = (kind == KErr);
          end
        end
      end
      exp_seen = exp_seen | sel;
      fd = &exp_seen;
      if (fd) exp_seen = '0;
      if (fd || {nd, nv, ne} != {exp_dig, exp_val, exp_err}) begin
        e.cyc = c + STABLE + 1; e.dig = nd; e.val = nv; e.err = ne; e.fd = fd;
        q.push_back(e);
      end
      exp_dig = nd; exp_val = nv; exp_err = ne;
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  initial begin
    int   c;
    exp_t e;
    reset = 1'b1;
    segs_n = 7'($urandom);
    dig_sel = 6'($urandom);
    @(posedge clk);
    segs_n = 7'($urandom);
    dig_sel = 6'($urandom);
    @(posedge clk);
    #1;
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_valid", 32'(dig_valid), 32'h0);
    check("reset_err", 32'(dig_err), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    segs_n = 7'h7F;
    dig_sel = '0;
    prev = {digits, dig_valid, dig_err};
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Latency: value 2 on digit 2, then a too-short window on digit 0
    apply(7'b0100100, 6'b000100, 5, KLeg, 4'h2);
    apply(7'b0100100, 6'b000001, 3, KNone, 4'h0);
    apply(7'h7F, 6'b000000, 6, KNone, 4'h0);

    // Two full scans of 1..6
    for (int s = 0; s < 2; s++) begin
      apply(7'b1111001, 6'b000001, 6, KLeg, 4'h1);
      apply(7'b0100100, 6'b000010, 6, KLeg, 4'h2);
      apply(7'b0110000, 6'b000100, 6, KLeg, 4'h3);
      apply(7'b0011001, 6'b001000, 6, KLeg, 4'h4);
      apply(7'b0010010, 6'b010000, 6, KLeg, 4'h5);
      apply(7'b0000010, 6'b100000, 6, KLeg, 4'h6);
    end
    check("scan_digits", 32'(digits), 32'h654321);
    check("scan_valid", 32'(dig_valid), 32'h3F);

    // Illegal 9-variant and blank on digit 1, then remaining glyphs
    apply(7'b0011000, 6'b000010, 6, KLeg, 4'h9);
    apply(7'b0010000, 6'b000010, 6, KErr, 4'h0);
    check("err_keeps_nibble", 32'(digits[7:4]), 32'h9);
    apply(7'b1111111, 6'b000010, 6, KBlank, 4'h0);
    apply(7'b0001000, 6'b000001, 6, KLeg, 4'hA);
    apply(7'b0000011, 6'b001000, 6, KLeg, 4'hB);
    apply(7'b1000110, 6'b010000, 6, KLeg, 4'hC);
    apply(7'b0100001, 6'b100000, 6, KLeg, 4'hD);
    apply(7'b0000110, 6'b000100, 6, KLeg, 4'hE);
    apply(7'b0001110, 6'b000001, 6, KLeg, 4'hF);
    apply(7'b1000000, 6'b001000, 6, KLeg, 4'h0);
    apply(7'b1111000, 6'b010000, 6, KLeg, 4'h7);
    apply(7'b0000000, 6'b100000, 6, KLeg, 4'h8);

    // Multi-hot select, then a one-cycle glitch inside a window
    apply(7'b1111001, 6'b000011, 10, KNone, 4'h0);
    apply(7'b0100100, 6'b000010, 2, KNone, 4'h0);
    apply(7'b1111111, 6'b000010, 1, KNone, 4'h0);
    apply(7'b0100100, 6'b000010, 6, KLeg, 4'h2);

    // Reset on the edge before acceptance
    c = cyc;
    segs_n = 7'b0011001;
    dig_sel = 6'b001000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    segs_n = 7'h7F;
    dig_sel = '0;
    e.cyc = c + STABLE; e.dig = '0; e.val = '0; e.err = '0; e.fd = 1'b0;
    q.push_back(e);
    exp_dig = '0; exp_val = '0; exp_err = '0; exp_seen = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_digits", 32'(digits), 32'h0);

    // Frame tracking restarts: digit 2 alone must not complete a frame
    apply(7'b0010010, 6'b000100, 6, KLeg, 4'h5);
    apply(7'b1111001, 6'b000001, 6, KLeg, 4'h1);
    apply(7'b0110000, 6'b000010, 6, KLeg, 4'h3);
    apply(7'b0000010, 6'b001000, 6, KLeg, 4'h6);
    apply(7'b1111000, 6'b010000, 6, KLeg, 4'h7);
    apply(7'b0000000, 6'b100000, 6, KLeg, 4'h8);
    apply(7'h7F, 6'b000000, 10, KNone, 4'h0);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
